// File: rtl/simon_pkg.sv
// Shared types and word helpers for the iterative Simon core.
// Helpers work on 64-bit containers with an explicit word width n (n <= 64).
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYFWD = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // z_J sequences; bit [61] is element 0.
  localparam logic [61:0] Z_SEQ [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  function automatic logic z_bit(input logic [61:0] z, input logic [5:0] idx);
    return z[6'd61 - idx];
  endfunction

  function automatic logic [63:0] simon_rol(input logic [63:0] x, input int unsigned s,
                                            input int unsigned n);
    logic [63:0] mask;
    mask = (n >= 32'd64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    return ((x << s) | (x >> (n - s))) & mask;
  endfunction

  function automatic logic [63:0] simon_ror(input logic [63:0] x, input int unsigned s,
                                            input int unsigned n);
    return simon_rol(x, n - s, n);
  endfunction

  function automatic logic [63:0] simon_f(input logic [63:0] x, input int unsigned n);
    return (simon_rol(x, 32'd1, n) & simon_rol(x, 32'd8, n)) ^ simon_rol(x, 32'd2, n);
  endfunction

endpackage

// File: rtl/simon_round.sv
// Combinational Simon round: forward (inv_i=0) or inverse (inv_i=1) Feistel step.
module simon_round
  import simon_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] k_i,
  input  logic         inv_i,
  output logic [N-1:0] x_o,
  output logic [N-1:0] y_o
);

  logic [N-1:0] fx_s;
  logic [N-1:0] fy_s;

  assign fx_s = N'(simon_f(64'(x_i), N));
  assign fy_s = N'(simon_f(64'(y_i), N));

  assign x_o = inv_i ? y_i : (y_i ^ fx_s ^ k_i);
  assign y_o = inv_i ? (x_i ^ fy_s ^ k_i) : x_i;

endmodule

// File: rtl/simon_iter_core.sv
// Iterative Simon block cipher core: one round per clock, key expanded on the fly.
// Optional macro SIMON_DECRYPT_EN adds in_decrypt and the KEYFWD + inverse-round path.
module simon_iter_core
  import simon_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int J = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_high,
  input  logic [N-1:0]   in_low,
  input  logic [M*N-1:0] in_key,
`ifdef SIMON_DECRYPT_EN
  input  logic           in_decrypt,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_high,
  output logic [N-1:0]   out_low,
  output logic           busy
);

  localparam int RW = $clog2(T + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(T - 1);
`ifdef SIMON_DECRYPT_EN
  localparam logic [RW-1:0] KF_LAST = RW'(T - M - 1);
`endif
  localparam logic [61:0]  ZJ = Z_SEQ[J];
  localparam logic [N-1:0] C3 = {{(N-2){1'b0}}, 2'b11};

  state_t                 state_q;
  logic [RW-1:0]          rnd_q;
  logic [5:0]             z_q;
  logic [N-1:0]           x_q, y_q, out_x_q, out_y_q;
  logic [M-1:0][N-1:0]    win_q;
  logic                   in_ready_q, out_valid_q, busy_q;
  logic                   dec_s;

  logic [N-1:0]           zv_s, tf_s, nf_s, tb_s, nb_s, rk_s, rx_s, ry_s;
  logic [M-1:0][N-1:0]    win_fwd_s, win_bwd_s;
  logic [5:0]             z_inc_s, z_dec_s;

`ifdef SIMON_DECRYPT_EN
  logic dec_q;
  assign dec_s = dec_q;
`else
  assign dec_s = 1'b0;
`endif

  // Forward step yields k[i+M] from window k[i..i+M-1]; backward step yields k[i] from k[i+1..i+M].
  assign zv_s      = {{(N-1){1'b0}}, z_bit(ZJ, z_q)};
  assign tf_s      = N'(simon_ror(64'(win_q[M-1]), 32'd3, N)) ^ ((M == 4) ? win_q[1] : {N{1'b0}});
  assign nf_s      = ~win_q[0] ^ tf_s ^ N'(simon_ror(64'(tf_s), 32'd1, N)) ^ zv_s ^ C3;
  assign tb_s      = N'(simon_ror(64'(win_q[M-2]), 32'd3, N)) ^ ((M == 4) ? win_q[0] : {N{1'b0}});
  assign nb_s      = ~win_q[M-1] ^ tb_s ^ N'(simon_ror(64'(tb_s), 32'd1, N)) ^ zv_s ^ C3;
  assign win_fwd_s = {nf_s, win_q[M-1:1]};
  assign win_bwd_s = {win_q[M-2:0], nb_s};
  assign z_inc_s   = (z_q == 6'd61) ? 6'd0 : z_q + 6'd1;
  assign z_dec_s   = (z_q == 6'd0) ? 6'd61 : z_q - 6'd1;
  assign rk_s      = dec_s ? win_q[M-1] : win_q[0];

  simon_round #(.N(N)) u_round (
    .x_i   (x_q),
    .y_i   (y_q),
    .k_i   (rk_s),
    .inv_i (dec_s),
    .x_o   (rx_s),
    .y_o   (ry_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= {RW{1'b0}};
      z_q         <= 6'd0;
      x_q         <= {N{1'b0}};
      y_q         <= {N{1'b0}};
      win_q       <= {(M*N){1'b0}};
      out_x_q     <= {N{1'b0}};
      out_y_q     <= {N{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SIMON_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= in_high;
            y_q        <= in_low;
            win_q      <= in_key;
            rnd_q      <= {RW{1'b0}};
            z_q        <= 6'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SIMON_DECRYPT_EN
            dec_q      <= in_decrypt;
            state_q    <= in_decrypt ? KEYFWD : RUN;
`else
            state_q    <= RUN;
`endif
          end
        end
`ifdef SIMON_DECRYPT_EN
        // z is left on T-M-1 at the end so the backward schedule starts on the right index.
        KEYFWD: begin
          win_q <= win_fwd_s;
          if (rnd_q == KF_LAST) begin
            rnd_q   <= {RW{1'b0}};
            state_q <= RUN;
          end else begin
            rnd_q <= rnd_q + RW'(1'b1);
            z_q   <= z_inc_s;
          end
        end
`endif
        RUN: begin
          x_q   <= rx_s;
          y_q   <= ry_s;
          win_q <= dec_s ? win_bwd_s : win_fwd_s;
          z_q   <= dec_s ? z_dec_s : z_inc_s;
          if (rnd_q == RUN_LAST) begin
            state_q     <= DONE;
            out_x_q     <= rx_s;
            out_y_q     <= ry_s;
            out_valid_q <= 1'b1;
          end else begin
            rnd_q <= rnd_q + RW'(1'b1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_high  = out_x_q;
  assign out_low   = out_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_simon_iter_core.sv
// Directed bench for simon_iter_core: Simon32/64 and Simon64/128 instances.
module tb_simon_iter_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_high, a_in_low, a_out_high, a_out_low;
  logic [63:0] a_in_key;
`ifdef SIMON_DECRYPT_EN
  logic        a_in_decrypt;
`endif
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0]  b_in_high, b_in_low, b_out_high, b_out_low;
  logic [127:0] b_in_key;

  simon_iter_core #(.N(16), .M(4), .T(32), .J(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_high(a_in_high), .in_low(a_in_low), .in_key(a_in_key),
`ifdef SIMON_DECRYPT_EN
    .in_decrypt(a_in_decrypt),
`endif
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_high(a_out_high), .out_low(a_out_low), .busy(a_busy)
  );

  simon_iter_core #(.N(32), .M(4), .T(44), .J(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_high(b_in_high), .in_low(b_in_low), .in_key(b_in_key),
`ifdef SIMON_DECRYPT_EN
    .in_decrypt(1'b0),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_high(b_out_high), .out_low(b_out_low), .busy(b_busy)
  );

  typedef struct {
    logic [63:0] key;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] ex;
    logic [15:0] ey;
  } vec_t;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rl16(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  // Textbook Simon32/64: full key expansion up front, then 32 rounds.
  function automatic logic [31:0] simon32_ref(input logic [63:0] key, input logic [15:0] px,
                                              input logic [15:0] py);
    logic [61:0] z0;
    logic [15:0] k [32];
    logic [15:0] tmp, x, y, t;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      tmp = rl16(k[i+3], 13) ^ k[i+1];
      tmp = tmp ^ rl16(tmp, 15);
      k[i+4] = ~k[i] ^ tmp ^ {15'd0, z0[61-i]} ^ 16'h0003;
    end
    x = px;
    y = py;
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rl16(x, 1) & rl16(x, 8)) ^ rl16(x, 2) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic vec_t mk(input logic [63:0] key, input logic [15:0] x, input logic [15:0] y);
    vec_t v;
    v.key = key;
    v.x   = x;
    v.y   = y;
    {v.ex, v.ey} = simon32_ref(key, x, y);
    return v;
  endfunction

  // Offer one block to dut_a, wait for its result and check latency and data (result left in DONE).
  task automatic run_a(input string name, input logic [63:0] key, input logic [15:0] x,
                       input logic [15:0] y, input logic dec, input logic [15:0] ex,
                       input logic [15:0] ey);
    int lat;
    int exp_lat;
    exp_lat = dec ? 60 : 32;
    @(negedge clk);
    check({name, " in_ready"}, 64'(a_in_ready), 64'd1);
    a_in_key   = key;
    a_in_high  = x;
    a_in_low   = y;
`ifdef SIMON_DECRYPT_EN
    a_in_decrypt = dec;
`endif
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, {32'd0, a_out_high, a_out_low}, {32'd0, ex, ey});
  endtask

  task automatic consume_a(input string name);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check({name, " out_valid drop"}, 64'(a_out_valid), 64'd0);
    check({name, " back to idle"}, {62'd0, a_in_ready, a_busy}, 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_key = 64'd0; a_in_high = 16'd0; a_in_low = 16'd0;
`ifdef SIMON_DECRYPT_EN
    a_in_decrypt = 1'b0;
`endif
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_key = 128'd0; b_in_high = 32'd0; b_in_low = 32'd0;
    rst_n = 1'b0;

    vecs[0].key = 64'h1918_1110_0908_0100; vecs[0].x = 16'h6565; vecs[0].y = 16'h6877;
    vecs[0].ex  = 16'hc69b;                vecs[0].ey = 16'he9bb;
    vecs[1] = mk(64'h0000_0000_0000_0000, 16'h0000, 16'h0000);
    vecs[2] = mk(64'hffff_ffff_ffff_ffff, 16'hffff, 16'hffff);
    vecs[3] = mk(64'h0123_4567_89ab_cdef, 16'hdead, 16'hbeef);
    vecs[4] = vecs[0];

    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(a_in_ready), 64'd1);
    check("reset out_valid", 64'(a_out_valid), 64'd0);
    check("reset outputs", {32'd0, a_out_high, a_out_low}, 64'd0);
    check("reset busy", 64'(a_busy), 64'd0);
    check("reset b state", {61'd0, b_in_ready, b_out_valid, b_busy}, 64'b100);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back blocks with differing keys; last row repeats the first.
    for (int i = 0; i < 5; i++) begin
      run_a($sformatf("vec%0d", i), vecs[i].key, vecs[i].x, vecs[i].y, 1'b0, vecs[i].ex, vecs[i].ey);
      consume_a($sformatf("vec%0d", i));
    end

    // Simon64/128 instance.
    @(negedge clk);
    b_in_key   = 128'h1b1a1918_13121110_0b0a0908_03020100;
    b_in_high  = 32'h656b696c;
    b_in_low   = 32'h20646e75;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (b_out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("s64 latency", 64'(lat), 64'd44);
    check("s64 result", {b_out_high, b_out_low}, 64'h44c8fc20_b9dfa07a);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("s64 consume", {62'd0, b_out_valid, b_in_ready}, 64'b01);

    // Backpressure: hold in DONE for 10 clocks while a new block is offered.
    run_a("bp", vecs[0].key, vecs[0].x, vecs[0].y, 1'b0, vecs[0].ex, vecs[0].ey);
    for (int c = 0; c < 10; c++) begin
      a_in_key = 64'h0; a_in_high = 16'h1234; a_in_low = 16'h5678; a_in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp hold %0d", c), {29'd0, a_out_valid, a_in_ready, a_busy, a_out_high, a_out_low},
            {29'd0, 3'b101, 16'hc69b, 16'he9bb});
    end
    a_in_valid = 1'b0;
    consume_a("bp");

    // Block after ignored offers, with out_ready held high through the run.
    a_out_ready = 1'b1;
    run_a("ordy", vecs[3].key, vecs[3].x, vecs[3].y, 1'b0, vecs[3].ex, vecs[3].ey);
    @(negedge clk);
    a_out_ready = 1'b0;
    check("ordy auto-consume", {62'd0, a_out_valid, a_in_ready}, 64'b01);

    // Asynchronous reset at round 10.
    a_in_key = vecs[0].key; a_in_high = vecs[0].x; a_in_low = vecs[0].y; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun busy", 64'(a_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(a_out_valid), 64'd0);
    check("abort outputs", {32'd0, a_out_high, a_out_low}, 64'd0);
    check("abort in_ready", {62'd0, a_in_ready, a_busy}, 64'b10);
    @(negedge clk);
    rst_n = 1'b1;
    run_a("after abort", vecs[0].key, vecs[0].x, vecs[0].y, 1'b0, vecs[0].ex, vecs[0].ey);
    consume_a("after abort");

`ifdef SIMON_DECRYPT_EN
    run_a("decrypt", vecs[0].key, 16'hc69b, 16'he9bb, 1'b1, 16'h6565, 16'h6877);
    consume_a("decrypt");
    run_a("enc after dec", vecs[3].key, vecs[3].x, vecs[3].y, 1'b0, vecs[3].ex, vecs[3].ey);
    consume_a("enc after dec");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
